jesd204b_rx_cgs: RTL and testbench
==================================

Name: jesd204b_rx_cgs

Overview:
Receive-side code group synchronization (CGS) controller for one JESD204B lane. It is the counterpart of the transmitter's /K/ (K28.5) emission. It sits after Dec8B10B and before the descrambler. It watches decoded characters and decoder error flags, drives the active-low SYNC~ request back to the transmitter, and declares the lane synchronized. It also drops back to resynchronization when the character error rate becomes too high.

Parameters:
K_COUNT, 4, consecutive valid /K/ characters required to leave CS_INIT
SYNC_LOW_MIN, 5, minimum clk cycles sync_n is held low after entering CS_INIT
ERR_LIMIT, 3, error-counter value that forces a return to CS_INIT
ERR_W, 2, width of err_cnt; must satisfy 2^ERR_W > ERR_LIMIT

Ports:
clk  input  1  byte clock, rising edge
reset  input  1  synchronous, active-high
en  input  1  lane enable; when low the FSM is held in CS_INIT
resync  input  1  single-cycle request forcing CS_INIT
in_valid  input  1  qualifies in_data, k_in, disp_err, code_err
in_data  input  8  decoded character from Dec8B10B
k_in  input  1  control-character flag from Dec8B10B
disp_err  input  1  disparity error from Dec8B10B
code_err  input  1  code error from Dec8B10B
sync_n  output  1  SYNC~ to transmitter; 0 = synchronization request
cgs_done  output  1  1 while in CS_DATA
state  output  1  0 = CS_INIT, 1 = CS_DATA
err_cnt  output  ERR_W  current error counter

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: state=CS_INIT, sync_n=0, cgs_done=0, err_cnt=0. Internal k_cnt, low_cnt and vld_run are also 0.
- Character classes, evaluated only when in_valid=1:
  - validK = k_in & in_data==8'hBC & !disp_err & !code_err
  - bad = disp_err | code_err
  - good = !bad
- in_valid=0: all counters hold and no transition occurs. low_cnt is the exception (see CS_INIT).
- Priority per edge: reset > !en > resync > normal FSM.
- !en or resync: next state is CS_INIT with sync_n=0, cgs_done=0, and all counters cleared.
- CS_INIT (sync_n=0):
  - low_cnt increments every cycle while en=1, saturating at SYNC_LOW_MIN-1. It counts regardless of in_valid.
  - validK increments k_cnt, saturating at K_COUNT-1.
  - Any valid non-validK character clears k_cnt.
  - Transition at the edge where the sampled character is validK, registered k_cnt >= K_COUNT-1, and registered low_cnt >= SYNC_LOW_MIN-1. Next state is CS_DATA with sync_n=1, cgs_done=1, err_cnt=0, vld_run=0.
  - If /K/ characters arrive before the hold-low time has expired, the FSM keeps waiting; the transition happens on the first validK after low_cnt saturates.
- CS_DATA (sync_n=1, cgs_done=1):
  - On bad: err_cnt += 1 and vld_run is cleared. If err_cnt+1 == ERR_LIMIT, next state is CS_INIT instead: sync_n=0, cgs_done=0, err_cnt=0, low_cnt=0, k_cnt=0.
  - On good (K or data): vld_run += 1. When vld_run reaches 3 (the 4th consecutive good character), vld_run is cleared and err_cnt decrements, saturating at 0.
- Latency: output changes are visible one clk after the triggering character is sampled.
- Reset or resync mid-operation drops sync immediately at the next edge and restarts the hold-low time.

Test Plan:
1. Assert reset for 2 cycles, en=1 -> sync_n=0, cgs_done=0, state=0, err_cnt=0.
2. Release reset with validK (0xBC, k_in=1) on edges 0..4 -> sync_n=1, state=1 after edge 4. Repeat with only K,K,K,K then 0x00 -> stays CS_INIT, k_cnt cleared.
3. In CS_INIT, feed K,K,K, then a K with code_err=1, then 5 validK -> transition only on the 4th clean K after the error, provided low_cnt is saturated.
4. In CS_DATA, feed bad,good,bad,good,bad -> err_cnt goes 1, 1, 2, 2. On the 3rd bad: state=0, sync_n=0, err_cnt=0 the next cycle.
5. In CS_DATA, feed bad, then 4 good data bytes -> err_cnt 1 then 0. Then in_valid=0 for 10 cycles -> no change.
6. In CS_DATA: a resync pulse -> CS_INIT next edge. en=0 while feeding validK -> stays in CS_INIT with sync_n=0. Raising reset with en=1 and resync=1 -> reset values.

Source files
------------

// File: rtl/jesd204b_rx_cgs.sv
// JESD204B receive-lane code group synchronization controller.
// Drives SYNC~ from decoded /K/ runs and the character error rate.
module jesd204b_rx_cgs #(
    parameter int K_COUNT      = 4,
    parameter int SYNC_LOW_MIN = 5,
    parameter int ERR_LIMIT    = 3,
    parameter int ERR_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             resync,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             k_in,
    input  logic             disp_err,
    input  logic             code_err,
    output logic             sync_n,
    output logic             cgs_done,
    output logic             state,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int KW = (K_COUNT > 1) ? $clog2(K_COUNT) : 1;
    localparam int LW = (SYNC_LOW_MIN > 1) ? $clog2(SYNC_LOW_MIN) : 1;

    localparam logic [KW-1:0]    K_MAX  = KW'(K_COUNT - 1);
    localparam logic [LW-1:0]    L_MAX  = LW'(SYNC_LOW_MIN - 1);
    localparam logic [ERR_W-1:0] E_TRIP = ERR_W'(ERR_LIMIT - 1);

    typedef enum logic {
        CS_INIT = 1'b0,
        CS_DATA = 1'b1
    } cgs_state_t;

    cgs_state_t       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LW-1:0]    low_q, low_d;
    logic [1:0]       vld_q, vld_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             sync_n_q, done_q;

    logic is_k, bad;

    assign is_k = k_in && (in_data == 8'hBC) && !disp_err && !code_err;
    assign bad  = disp_err || code_err;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        low_d   = low_q;
        vld_d   = vld_q;
        err_d   = err_q;
        if (!en || resync) begin
            state_d = CS_INIT;
            k_d     = '0;
            low_d   = '0;
            vld_d   = '0;
            err_d   = '0;
        end else begin
            unique case (state_q)
                CS_INIT: begin
                    // hold-low timer runs even without valid characters
                    if (low_q != L_MAX)
                        low_d = low_q + 1'b1;
                    if (in_valid) begin
                        if (is_k) begin
                            if (k_q >= K_MAX && low_q >= L_MAX) begin
                                state_d = CS_DATA;
                                k_d     = '0;
                                low_d   = '0;
                                vld_d   = '0;
                                err_d   = '0;
                            end else if (k_q != K_MAX) begin
                                k_d = k_q + 1'b1;
                            end
                        end else begin
                            k_d = '0;
                        end
                    end
                end
                CS_DATA: begin
                    if (in_valid) begin
                        if (bad) begin
                            vld_d = '0;
                            if (err_q == E_TRIP) begin
                                state_d = CS_INIT;
                                err_d   = '0;
                                low_d   = '0;
                                k_d     = '0;
                            end else begin
                                err_d = err_q + 1'b1;
                            end
                        end else if (vld_q == 2'd3) begin
                            // four clean characters in a row forgive one error
                            vld_d = '0;
                            if (err_q != '0)
                                err_d = err_q - 1'b1;
                        end else begin
                            vld_d = vld_q + 1'b1;
                        end
                    end
                end
                default: state_d = CS_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CS_INIT;
            k_q      <= '0;
            low_q    <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            sync_n_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            low_q    <= low_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            sync_n_q <= (state_d == CS_DATA);
            done_q   <= (state_d == CS_DATA);
        end
    end

    assign state    = state_q;
    assign sync_n   = sync_n_q;
    assign cgs_done = done_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_jesd204b_rx_cgs.sv
// Directed bench for jesd204b_rx_cgs with hand-computed expectations.
module tb_jesd204b_rx_cgs;

    logic       clk = 1'b0;
    logic       reset, en, resync;
    logic       in_valid, k_in, disp_err, code_err;
    logic [7:0] in_data;
    logic       sync_n, cgs_done, state;
    logic [1:0] err_cnt;

    int passes = 0;
    int total  = 0;

    jesd204b_rx_cgs #(
        .K_COUNT(4),
        .SYNC_LOW_MIN(5),
        .ERR_LIMIT(3),
        .ERR_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .resync(resync),
        .in_valid(in_valid),
        .in_data(in_data),
        .k_in(k_in),
        .disp_err(disp_err),
        .code_err(code_err),
        .sync_n(sync_n),
        .cgs_done(cgs_done),
        .state(state),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k,
                         input logic de, input logic ce);
        in_valid = v;
        in_data  = d;
        k_in     = k;
        disp_err = de;
        code_err = ce;
    endtask

    task automatic kchar(input int n);
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lane(input string tag, input logic s, input logic [1:0] e);
        chk({tag, "_state"}, {7'd0, state}, {7'd0, s});
        chk({tag, "_sync"}, {7'd0, sync_n}, {7'd0, s});
        chk({tag, "_done"}, {7'd0, cgs_done}, {7'd0, s});
        chk({tag, "_err"}, {6'd0, err_cnt}, {6'd0, e});
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        tick();
        resync = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        resync = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        tick();
        lane("reset", 1'b0, 2'd0);

        // clean /K/ from release: hold-low expires, sync on 5th edge
        reset = 1'b0;
        kchar(4);
        lane("k4_wait", 1'b0, 2'd0);
        kchar(1);
        lane("k5_sync", 1'b1, 2'd0);

        // four /K/ then a data byte clears the /K/ run
        pulse_resync();
        lane("resync1", 1'b0, 2'd0);
        kchar(4);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        lane("kbreak", 1'b0, 2'd0);
        kchar(3);
        lane("krestart3", 1'b0, 2'd0);
        kchar(1);
        lane("krestart4", 1'b1, 2'd0);

        // an errored /K/ restarts the count
        pulse_resync();
        kchar(3);
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
        tick();
        lane("kcodeerr", 1'b0, 2'd0);
        kchar(3);
        lane("kerr_after3", 1'b0, 2'd0);
        kchar(1);
        lane("kerr_after4", 1'b1, 2'd0);
        kchar(1);
        lane("kerr_after5", 1'b1, 2'd0);

        // error accumulation drops the link on the third net error
        drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bad1", {6'd0, err_cnt}, 8'd1);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        chk("good1", {6'd0, err_cnt}, 8'd1);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bad2", {6'd0, err_cnt}, 8'd2);
        drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        tick();
        lane("good2", 1'b1, 2'd2);
        drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        tick();
        lane("bad3_drop", 1'b0, 2'd0);

        // resync after error drop restarts the hold-low time
        kchar(4);
        lane("relock4", 1'b0, 2'd0);
        kchar(1);
        lane("relock5", 1'b1, 2'd0);

        // four good characters forgive one error
        drive(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fbad", {6'd0, err_cnt}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("fgood3", {6'd0, err_cnt}, 8'd1);
        drive(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        tick();
        lane("fgood4", 1'b1, 2'd0);
        drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        tick();
        chk("hbad", {6'd0, err_cnt}, 8'd1);
        drive(1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        lane("idle10", 1'b1, 2'd1);

        // resync, lane disable and reset
        pulse_resync();
        lane("resync2", 1'b0, 2'd0);
        en = 1'b0;
        kchar(8);
        lane("en_low", 1'b0, 2'd0);
        en = 1'b1;
        kchar(4);
        lane("en_up4", 1'b0, 2'd0);
        kchar(1);
        lane("en_up5", 1'b1, 2'd0);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_reset_err", {6'd0, err_cnt}, 8'd1);
        reset  = 1'b1;
        resync = 1'b1;
        kchar(1);
        lane("reset2", 1'b0, 2'd0);
        reset  = 1'b0;
        resync = 1'b0;
        kchar(4);
        lane("post_reset4", 1'b0, 2'd0);
        kchar(1);
        lane("post_reset5", 1'b1, 2'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
